// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
// The fetch unit is the master: it drives the request and address.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage of a single-cycle MIPS core: owns the PC, fetches over a req/ack port,
// opens one execute window per instruction and computes the next PC.
module instr_fetch_unit #(
  parameter logic [31:0] ResetPc = 32'h0000_0000,
  parameter int unsigned Timeout = 15
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  instr_fetch_unit_if.master         imem,
  input  logic                       jump_i,
  input  logic                       branch_i,
  input  logic                       zero_i,
  input  logic                       stall_i,
  output logic [31:0]                instr_o,
  output logic [5:0]                 opcode_o,
  output logic [5:0]                 funct_o,
  output logic [4:0]                 rs_o,
  output logic [4:0]                 rt_o,
  output logic [4:0]                 rd_o,
  output logic [31:0]                sign_imm_o,
  output logic [31:0]                pc_plus4_o,
  output logic                       instr_valid_o,
  output logic                       fetch_err_o,
  output logic [31:0]                retired_o
);

  typedef enum logic [1:0] {StReset, StReq, StExec, StHalt} state_e;

  // Value wait_cnt holds during the last REQ cycle allowed before a timeout.
  localparam logic [7:0] WaitLast = 8'(Timeout - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [7:0]  wait_q, wait_d;
  logic        err_q, err_d;
  logic [31:0] retired_q, retired_d;

  logic [31:0] pc_plus4;
  logic [31:0] sign_imm;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] next_pc;

  assign pc_plus4      = pc_q + 32'd4;
  assign sign_imm      = {{16{ir_q[15]}}, ir_q[15:0]};
  assign jump_target   = {pc_plus4[31:28], ir_q[25:0], 2'b00};
  assign branch_target = pc_plus4 + (sign_imm << 2);

  // Jump wins over a taken branch.
  always_comb begin
    next_pc = pc_plus4;
    if (jump_i) begin
      next_pc = jump_target;
    end else if (branch_i && zero_i) begin
      next_pc = branch_target;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    wait_d        = wait_q;
    err_d         = err_q;
    retired_d     = retired_q;
    imem.imem_req = 1'b0;
    instr_valid_o = 1'b0;

    unique case (state_q)
      StReset: begin
        state_d = StReq;
      end
      StReq: begin
        imem.imem_req = 1'b1;
        // An ack in the timeout cycle still counts as a successful fetch.
        if (imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          state_d = StExec;
        end else if (wait_q == WaitLast) begin
          wait_d  = wait_q + 8'd1;
          err_d   = 1'b1;
          state_d = StHalt;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StExec: begin
        instr_valid_o = 1'b1;
        if (!stall_i) begin
          pc_d      = next_pc;
          retired_d = retired_q + 32'd1;
          wait_d    = 8'd0;
          state_d   = StReq;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StReset;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StReset;
      pc_q      <= ResetPc;
      ir_q      <= 32'h0;
      wait_q    <= 8'h0;
      err_q     <= 1'b0;
      retired_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  assign imem.imem_addr = pc_q;
  assign instr_o        = ir_q;
  assign opcode_o       = ir_q[31:26];
  assign rs_o           = ir_q[25:21];
  assign rt_o           = ir_q[20:16];
  assign rd_o           = ir_q[15:11];
  assign funct_o        = ir_q[5:0];
  assign sign_imm_o     = sign_imm;
  assign pc_plus4_o     = pc_plus4;
  assign fetch_err_o    = err_q;
  assign retired_o      = retired_q;

endmodule
